// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: issues one data-bus access per load/store and
// returns aligned, sign-extended load data to MEM/WB, stalling the pipe meanwhile.
module mem_lsu #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [7:0]  mem_aluop_i,
    input  logic [31:0] mem_mem_addr_i,
    input  logic [31:0] mem_reg2_i,
    input  logic        flush_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_wdata_o,
    output logic [3:0]  dbus_sel_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    input  logic        dbus_err_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic [31:0] exc_addr_o
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             is_mem, is_store, is_unsigned, misaligned, issue, timeout_hit;
    size_e            size;
    logic [3:0]       sel_d;
    logic [31:0]      store_data;

    size_e            size_q;
    logic             unsigned_q, store_q, wreg_q, err_q;
    logic [4:0]       wd_q;
    logic [31:0]      addr_q, rdata_q, shifted, load_data;

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        is_mem      = 1'b1;
        is_store    = 1'b0;
        is_unsigned = 1'b0;
        size        = SZ_W;
        case (mem_aluop_i)
            EXE_LB_OP:  size = SZ_B;
            EXE_LBU_OP: begin size = SZ_B; is_unsigned = 1'b1; end
            EXE_LH_OP:  size = SZ_H;
            EXE_LHU_OP: begin size = SZ_H; is_unsigned = 1'b1; end
            EXE_LW_OP:  size = SZ_W;
            EXE_SB_OP:  begin size = SZ_B; is_store = 1'b1; end
            EXE_SH_OP:  begin size = SZ_H; is_store = 1'b1; end
            EXE_SW_OP:  begin size = SZ_W; is_store = 1'b1; end
            default:    is_mem = 1'b0;
        endcase
    end

    assign misaligned  = is_mem && (((size == SZ_H) && mem_mem_addr_i[0]) ||
                                    ((size == SZ_W) && (mem_mem_addr_i[1:0] != 2'b00)));
    assign issue       = (state_q == IDLE) && is_mem && !misaligned && !flush_i;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

    always_comb begin
        sel_d      = 4'b1111;
        store_data = mem_reg2_i;
        case (size)
            SZ_B: begin
                sel_d      = 4'b0001 << mem_mem_addr_i[1:0];
                store_data = {4{mem_reg2_i[7:0]}};
            end
            SZ_H: begin
                sel_d      = mem_mem_addr_i[1] ? 4'b1100 : 4'b0011;
                store_data = {2{mem_reg2_i[15:0]}};
            end
            default: ;
        endcase
    end

    // A grant coinciding with a flush still leaves a response in flight, so drain it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (issue) state_d = REQ;
            REQ: begin
                if (flush_i)          state_d = dbus_gnt_i ? DRAIN : IDLE;
                else if (dbus_gnt_i)  state_d = WAIT;
                else if (timeout_hit) state_d = DONE;
            end
            WAIT: begin
                if (dbus_rvalid_i)    state_d = flush_i ? IDLE : DONE;
                else if (flush_i)     state_d = DRAIN;
                else if (timeout_hit) state_d = DONE;
            end
            DONE:  state_d = IDLE;
            DRAIN: if (dbus_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= ((state_d == state_q) && ((state_q == REQ) || (state_q == WAIT)))
                       ? cnt_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_wdata_o <= '0;
            dbus_sel_o   <= '0;
            addr_q       <= '0;
            wd_q         <= '0;
            wreg_q       <= 1'b0;
            size_q       <= SZ_B;
            unsigned_q   <= 1'b0;
            store_q      <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            dbus_req_o <= (state_d == REQ);
            if (issue) begin
                dbus_we_o    <= is_store;
                dbus_addr_o  <= {mem_mem_addr_i[31:2], 2'b00};
                dbus_wdata_o <= store_data;
                dbus_sel_o   <= sel_d;
                addr_q       <= mem_mem_addr_i;
                wd_q         <= mem_wd_i;
                wreg_q       <= mem_wreg_i;
                size_q       <= size;
                unsigned_q   <= is_unsigned;
                store_q      <= is_store;
                err_q        <= 1'b0;
            end else if ((state_q == WAIT) && dbus_rvalid_i) begin
                rdata_q <= dbus_rdata_i;
                err_q   <= dbus_err_i;
            end else if (((state_q == REQ) || (state_q == WAIT)) && (state_d == DONE)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign shifted = rdata_q >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_data = rdata_q;
        case (size_q)
            SZ_B: load_data = unsigned_q ? {24'b0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: load_data = unsigned_q ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        wd_o       = mem_wd_i;
        wreg_o     = 1'b0;
        wdata_o    = mem_wdata_i;
        stallreq_o = 1'b0;
        misalign_o = 1'b0;
        bus_err_o  = 1'b0;
        exc_addr_o = addr_q;
        case (state_q)
            IDLE: begin
                if (!is_mem) begin
                    wreg_o = mem_wreg_i;
                end else if (misaligned && !flush_i) begin
                    misalign_o = 1'b1;
                    exc_addr_o = mem_mem_addr_i;
                end else begin
                    stallreq_o = issue;
                end
            end
            REQ, WAIT: stallreq_o = 1'b1;
            DONE: begin
                wd_o    = wd_q;
                wdata_o = load_data;
                if (err_q)         bus_err_o = 1'b1;
                else if (!store_q) wreg_o    = wreg_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage load/store unit.
- Consumes the instruction held by the EX/MEM pipeline register and issues the data-bus transaction for loads and stores.
- Returns write-back information to the MEM/WB register, with byte/half extraction and sign extension.
- Raises a stall request while a transaction is outstanding, so the EX/MEM register holds and MEM/WB receives bubbles.

Parameters:
- TIMEOUT_CYC, 255, max cycles in REQ or WAIT before a forced bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- mem_wd_i  in  5  destination register address.
- mem_wreg_i  in  1  register-write enable.
- mem_wdata_i  in  32  ALU result (non-memory ops).
- mem_aluop_i  in  8  ALU op code (AluOpBus).
- mem_mem_addr_i  in  32  effective address.
- mem_reg2_i  in  32  store data.
- flush_i  in  1  pipeline flush.
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  1 = write.
- dbus_addr_o  out  32  word-aligned address.
- dbus_wdata_o  out  32  lane-replicated store data.
- dbus_sel_o  out  4  byte enables.
- dbus_gnt_i  in  1  request accepted.
- dbus_rvalid_i  in  1  response valid (load data or store ack).
- dbus_rdata_i  in  32  read data.
- dbus_err_i  in  1  response error, qualified by rvalid.
- wd_o  out  5  to MEM/WB.
- wreg_o  out  1  to MEM/WB.
- wdata_o  out  32  to MEM/WB.
- stallreq_o  out  1  stall request to the pipeline controller.
- misalign_o  out  1  one-cycle pulse: misaligned access.
- bus_err_o  out  1  one-cycle pulse: bus error or timeout.
- exc_addr_o  out  32  faulting address, valid with either pulse.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset state: FSM in IDLE, timeout counter 0. All registered outputs are 0: dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_sel_o, exc_addr_o. Latched result is 0. Combinational outputs evaluate in IDLE.
- A reset asserted mid-transaction abandons it; rvalid seen in IDLE is ignored.
- Memory ops: EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU, EXE_SB, EXE_SH, EXE_SW. All other ops are non-memory.
- Non-memory op in IDLE: wd_o, wreg_o and wdata_o pass through combinationally; stallreq_o = 0; zero added latency.
- Misalignment: H ops with addr[0] != 0, W ops with addr[1:0] != 0.
  - Misaligned op in IDLE: no request is issued.
  - misalign_o = 1 and exc_addr_o = addr for that cycle; wreg_o = 0; stallreq_o = 0.
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE, aligned memory op, flush_i = 0:
  - stallreq_o = 1, wreg_o = 0.
  - Latch op, wd and addr.
  - Register dbus_addr_o = {addr[31:2], 2'b00} and dbus_we_o (set for stores).
  - Byte enables: B → sel = 1 << addr[1:0]; H → addr[1] ? 1100 : 0011; W → 1111. Loads and stores use the same enables.
  - Store data: SB → {4{reg2[7:0]}}; SH → {2{reg2[15:0]}}; SW → reg2.
  - Next state REQ.
- REQ: dbus_req_o = 1, stallreq_o = 1; address and data stay stable until grant.
  - gnt → drop req, go WAIT.
  - flush_i before gnt → drop req, go IDLE, no write-back.
- WAIT: stallreq_o = 1.
  - rvalid → latch result, go DONE.
  - flush_i → go DRAIN.
  - rvalid takes priority over a same-cycle flush; the result is then discarded (state DRAIN→IDLE semantics, no write-back).
- Load result: byte = rdata >> (8 * addr[1:0]).
  - LB sign-extends bit 7; LBU zero-extends.
  - LH sign-extends bit 15; LHU zero-extends.
  - LW takes the full word.
- DONE: stallreq_o = 0; lasts exactly one cycle; no re-issue of the same access; then IDLE.
  - Load without error: wreg_o = latched wreg, wd_o = latched wd, wdata_o = extracted data.
  - Store: wreg_o = 0.
  - dbus_err_i was set with rvalid: bus_err_o = 1, exc_addr_o = addr, wreg_o = 0.
- DRAIN: stallreq_o = 0; wreg_o = 0; wait for rvalid, discard it, then IDLE. A new memory op is not issued until IDLE.
- Timeout: counter increments in REQ/WAIT and clears on state change.
  - Reaching TIMEOUT_CYC goes to DONE with the error flagged; bus_err_o pulses.
  - A late rvalid arriving afterwards is ignored in IDLE.
- Latency, aligned access with gnt and rvalid immediate: IDLE, REQ, WAIT, DONE = 4 cycles in stage. Stall is asserted 3 cycles; MEM/WB captures on the DONE edge.

Test Plan:
- ADD result 0x1234, wd = 5, wreg = 1 → same-cycle wreg_o = 1, wdata_o = 0x1234, stallreq_o never set.
- LB addr 0x1003, rdata 0x80AA5511 (gnt in REQ, rvalid next cycle) → sel = 1000, dbus_addr_o = 0x1000, stallreq_o high 3 cycles, DONE wdata_o = 0xFFFFFF80. LBU variant → 0x00000080.
- SH addr 0x2002, reg2 0xDEADBEEF, gnt delayed 3 cycles → req held with stable addr 0x2000, sel = 1100, wdata = 0xBEEFBEEF; DONE wreg_o = 0.
- LW addr 0x3001 → no dbus_req_o, misalign_o = 1, exc_addr_o = 0x3001, no stall.
- LW with dbus_err_i at rvalid → bus_err_o pulse in DONE, wreg_o = 0; separately, no rvalid for 255 cycles → timeout bus_err_o.
- flush_i in WAIT → DRAIN, rvalid absorbed, no write-back. rst asserted in WAIT → all outputs 0 and IDLE immediately; a following rvalid is ignored.
